// File: rtl/phase_cycle_shifter_pkg.sv
// Shared definitions for the phase-cycling TX/RX quadrature shifter:
// phase codes and the layout of one {TX, RX} phase-table entry.
package phase_cycle_shifter_pkg;

  // Quadrature phase codes in steps of 90 degrees.
  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_90  = 2'd1,
    PH_180 = 2'd2,
    PH_270 = 2'd3
  } phase_e;

  // One table entry is {TX_phase[1:0], RX_phase[1:0]}.
  localparam int ENTRY_W   = 4;
  localparam int PH_W      = 2;
  localparam int TX_PH_LSB = 2;
  localparam int RX_PH_LSB = 0;

endpackage

// File: rtl/phase_cycle_shifter_if.sv
// Data, table-programming and scan-control bundle of the phase shifter.
// The master drives DDS samples and control; the slave is the shifter.
interface phase_cycle_shifter_if #(
  parameter int N_PARA_TX   = 8,
  parameter int IN_BITS     = 16,
  parameter int N_BITS_TX   = 14,
  parameter int N_PARA_RX   = N_PARA_TX / 2,
  parameter int CYCLE_DEPTH = 8
);
  localparam int AW = $clog2(CYCLE_DEPTH);

  logic [N_PARA_TX*IN_BITS-1:0]                 I_in;
  logic [N_PARA_TX*IN_BITS-1:0]                 Q_in;
  logic                                         in_valid;
  logic                                         tbl_wr_en;
  logic [AW-1:0]                                tbl_wr_addr;
  logic [phase_cycle_shifter_pkg::ENTRY_W-1:0]  tbl_wr_data;
  logic [AW:0]                                  cycle_len;
  logic                                         scan_done;
  logic                                         cycle_restart;

  logic [N_PARA_TX*N_BITS_TX-1:0]               RF_out;
  logic [N_PARA_RX*IN_BITS-1:0]                 LO_I_out;
  logic [N_PARA_RX*IN_BITS-1:0]                 LO_Q_out;
  logic                                         out_valid;
  logic [AW-1:0]                                scan_idx;
  logic [phase_cycle_shifter_pkg::ENTRY_W-1:0]  phases_active;

  modport master (
    output I_in, Q_in, in_valid, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
           cycle_len, scan_done, cycle_restart,
    input  RF_out, LO_I_out, LO_Q_out, out_valid, scan_idx, phases_active
  );

  modport slave (
    input  I_in, Q_in, in_valid, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
           cycle_len, scan_done, cycle_restart,
    output RF_out, LO_I_out, LO_Q_out, out_valid, scan_idx, phases_active
  );

endinterface

// File: rtl/phase_cycle_shifter_iq_rotate_sat.sv
// Combinational rotation of one I/Q sample by a multiple of 90 degrees.
// Negation saturates so the most negative value maps to the most positive.
module iq_rotate_sat #(
  parameter int IN_BITS = 16
) (
  input  logic signed [IN_BITS-1:0] i_data_i,
  input  logic signed [IN_BITS-1:0] i_data_q,
  input  logic        [1:0]         i_phase,
  output logic signed [IN_BITS-1:0] o_data_i,
  output logic signed [IN_BITS-1:0] o_data_q
);
  import phase_cycle_shifter_pkg::*;

  localparam logic signed [IN_BITS-1:0] MIN_VAL = {1'b1, {(IN_BITS-1){1'b0}}};
  localparam logic signed [IN_BITS-1:0] MAX_VAL = {1'b0, {(IN_BITS-1){1'b1}}};

  function automatic logic signed [IN_BITS-1:0] neg_sat(input logic signed [IN_BITS-1:0] x);
    return (x == MIN_VAL) ? MAX_VAL : -x;
  endfunction

  // Select the rotated pair for the requested quadrant.
  // NOTE: both outputs get a default first so no path through the case infers a latch.
  always_comb begin
    o_data_i = i_data_i;
    o_data_q = i_data_q;
    case (i_phase)
      PH_0:   begin o_data_i = i_data_i;          o_data_q = i_data_q;          end
      PH_90:  begin o_data_i = neg_sat(i_data_q); o_data_q = i_data_i;          end
      PH_180: begin o_data_i = neg_sat(i_data_i); o_data_q = neg_sat(i_data_q); end
      PH_270: begin o_data_i = i_data_q;          o_data_q = neg_sat(i_data_i); end
      default: ;
    endcase
  end

endmodule

// File: rtl/phase_cycle_shifter.sv
// Phase-cycling TX/RX quadrature shifter: a programmable table of phase
// pairs advanced once per scan, applied to the parallel DDS stream through
// a fixed two-stage pipeline (register inputs, register rotated outputs).
module phase_cycle_shifter #(
  parameter int N_PARA_TX   = 8,
  parameter int IN_BITS     = 16,
  parameter int N_BITS_TX   = 14,
  parameter int N_PARA_RX   = N_PARA_TX / 2,
  parameter int CYCLE_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  phase_cycle_shifter_if.slave bus
);
  import phase_cycle_shifter_pkg::*;

  localparam int            AW      = $clog2(CYCLE_DEPTH);
  localparam int            DEC     = N_PARA_TX / N_PARA_RX;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(CYCLE_DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);

  // Phase table and scan pointer.
  logic [ENTRY_W-1:0] r_tbl [CYCLE_DEPTH];
  logic [AW-1:0]      r_ptr;
  logic [AW-1:0]      w_ptr_nxt;
  logic [ENTRY_W-1:0] r_phases;
  logic [AW:0]        w_eff_len;
  logic               w_load;

  // Pipeline stage 1.
  logic [N_PARA_TX*IN_BITS-1:0] r_s1_i;
  logic [N_PARA_TX*IN_BITS-1:0] r_s1_q;
  logic                         r_s1_valid;
  logic [ENTRY_W-1:0]           r_s1_phases;

  // Rotated lanes between stage 1 and stage 2.
  logic [N_PARA_TX*IN_BITS-1:0]   w_tx_rot_i;
  logic [N_PARA_TX*IN_BITS-1:0]   w_tx_rot_q;
  logic [N_PARA_TX*N_BITS_TX-1:0] w_rf;
  logic [N_PARA_RX*IN_BITS-1:0]   w_lo_i;
  logic [N_PARA_RX*IN_BITS-1:0]   w_lo_q;

  // Pipeline stage 2.
  logic [N_PARA_TX*N_BITS_TX-1:0] r_rf;
  logic [N_PARA_RX*IN_BITS-1:0]   r_lo_i;
  logic [N_PARA_RX*IN_BITS-1:0]   r_lo_q;
  logic                           r_out_valid;

  // Clamp the programmed cycle length into 1..CYCLE_DEPTH.
  always_comb begin
    w_eff_len = bus.cycle_len;
    if (bus.cycle_len == '0)
      w_eff_len = ONE_W;
    else if (bus.cycle_len > DEPTH_W)
      w_eff_len = DEPTH_W;
  end

  // Next pointer: restart wins over scan_done; a pointer left past a shrunk
  // cycle length wraps on the next advance.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (bus.cycle_restart)
      w_ptr_nxt = '0;
    else if (bus.scan_done)
      w_ptr_nxt = ({1'b0, r_ptr} >= (w_eff_len - ONE_W)) ? '0 : r_ptr + AW'(1);
  end

  assign w_load = bus.cycle_restart | bus.scan_done;

  // Table write port, one entry per cycle.
  // NOTE: the table is reset explicitly because every entry must read 0 after reset;
  // this keeps it in flops rather than a RAM macro without a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < CYCLE_DEPTH; e++) r_tbl[e] <= '0;
    end else if (bus.tbl_wr_en) begin
      r_tbl[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end
  end

  // Advance the pointer and latch the active phase pair on scan boundaries.
  // NOTE: non-blocking assignment means this read of r_tbl sees the pre-write
  // contents when a write to the same entry lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_phases <= '0;
    end else if (w_load) begin
      r_ptr    <= w_ptr_nxt;
      r_phases <= r_tbl[w_ptr_nxt];
    end
  end

  // Stage 1: capture samples together with the phases they are rotated by.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_i      <= '0;
      r_s1_q      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_phases <= '0;
    end else begin
      r_s1_i      <= bus.I_in;
      r_s1_q      <= bus.Q_in;
      r_s1_valid  <= bus.in_valid;
      r_s1_phases <= r_phases;
    end
  end

  // TX lanes: rotate every DDS lane, keep the top N_BITS_TX bits of rotated I.
  for (genvar k = 0; k < N_PARA_TX; k++) begin : g_tx
    iq_rotate_sat #(.IN_BITS(IN_BITS)) u_rot (
      .i_data_i (r_s1_i[k*IN_BITS +: IN_BITS]),
      .i_data_q (r_s1_q[k*IN_BITS +: IN_BITS]),
      .i_phase  (r_s1_phases[TX_PH_LSB +: PH_W]),
      .o_data_i (w_tx_rot_i[k*IN_BITS +: IN_BITS]),
      .o_data_q (w_tx_rot_q[k*IN_BITS +: IN_BITS])
    );
    assign w_rf[k*N_BITS_TX +: N_BITS_TX] =
      w_tx_rot_i[k*IN_BITS + (IN_BITS - N_BITS_TX) +: N_BITS_TX];
  end

  // RX lanes: rotate the decimated DDS lanes at full width.
  for (genvar k = 0; k < N_PARA_RX; k++) begin : g_rx
    iq_rotate_sat #(.IN_BITS(IN_BITS)) u_rot (
      .i_data_i (r_s1_i[k*DEC*IN_BITS +: IN_BITS]),
      .i_data_q (r_s1_q[k*DEC*IN_BITS +: IN_BITS]),
      .i_phase  (r_s1_phases[RX_PH_LSB +: PH_W]),
      .o_data_i (w_lo_i[k*IN_BITS +: IN_BITS]),
      .o_data_q (w_lo_q[k*IN_BITS +: IN_BITS])
    );
  end

  // The TX path only needs rotated I, and only its upper bits.
  logic w_unused_tx;
  assign w_unused_tx = &{1'b0, w_tx_rot_q, w_tx_rot_i};

  // Stage 2: register rotated outputs; hold them while no valid data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf        <= '0;
      r_lo_i      <= '0;
      r_lo_q      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rf   <= w_rf;
        r_lo_i <= w_lo_i;
        r_lo_q <= w_lo_q;
      end
    end
  end

  assign bus.RF_out        = r_rf;
  assign bus.LO_I_out      = r_lo_i;
  assign bus.LO_Q_out      = r_lo_q;
  assign bus.out_valid     = r_out_valid;
  assign bus.scan_idx      = r_ptr;
  assign bus.phases_active = r_phases;

endmodule

// File: tb/tb_phase_cycle_shifter.sv
// Scoreboard bench for phase_cycle_shifter: stimulus pushes hand-computed
// expected words, an independent negedge monitor pops and compares them.
module tb_phase_cycle_shifter;

  localparam int NTX   = 8;
  localparam int IB    = 16;
  localparam int NB    = 14;
  localparam int NRX   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phase_cycle_shifter_if #(
    .N_PARA_TX(NTX), .IN_BITS(IB), .N_BITS_TX(NB), .N_PARA_RX(NRX), .CYCLE_DEPTH(DEPTH)
  ) bus ();

  phase_cycle_shifter #(
    .N_PARA_TX(NTX), .IN_BITS(IB), .N_BITS_TX(NB), .N_PARA_RX(NRX), .CYCLE_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NTX*NB-1:0] rf;
    logic [NRX*IB-1:0] loi;
    logic [NRX*IB-1:0] loq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid output word must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got out_valid=1 expected no output pending");
        end else begin
          e = exp_q.pop_front();
          check("rf_out",   128'(bus.RF_out),   128'(e.rf));
          check("lo_i_out", 128'(bus.LO_I_out), 128'(e.loi));
          check("lo_q_out", 128'(bus.LO_Q_out), 128'(e.loq));
        end
      end
    end
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100us");
    $fatal(1, "timeout");
  end

  task automatic clear_ctl();
    bus.tbl_wr_en     = 1'b0;
    bus.tbl_wr_addr   = '0;
    bus.tbl_wr_data   = '0;
    bus.scan_done     = 1'b0;
    bus.cycle_restart = 1'b0;
  endtask

  // One-cycle control pulse; returns just after the edge that sampled it.
  task automatic pulse(input logic sd, input logic cr, input logic wr,
                       input logic [2:0] waddr, input logic [3:0] wdata);
    @(posedge clk); #1;
    bus.scan_done     = sd;
    bus.cycle_restart = cr;
    bus.tbl_wr_en     = wr;
    bus.tbl_wr_addr   = waddr;
    bus.tbl_wr_data   = wdata;
    @(posedge clk); #1;
    clear_ctl();
  endtask

  task automatic check_scan(input string name, input logic [2:0] idx, input logic [3:0] ph);
    check({name, "_idx"}, 128'(bus.scan_idx), 128'(idx));
    check({name, "_ph"},  128'(bus.phases_active), 128'(ph));
  endtask

  // Drive one valid word with every lane equal; push the expected output.
  task automatic send(input logic [15:0] i, input logic [15:0] q,
                      input logic [13:0] rf, input logic [15:0] loi, input logic [15:0] loq);
    exp_t e;
    @(posedge clk); #1;
    bus.I_in     = {NTX{i}};
    bus.Q_in     = {NTX{q}};
    bus.in_valid = 1'b1;
    e.rf  = {NTX{rf}};
    e.loi = {NRX{loi}};
    e.loq = {NRX{loq}};
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst           = 1'b1;
    bus.I_in      = '0;
    bus.Q_in      = '0;
    bus.in_valid  = 1'b0;
    bus.cycle_len = 4'd4;
    clear_ctl();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_rf",        128'(bus.RF_out),    128'(0));
    check("rst_lo_i",      128'(bus.LO_I_out),  128'(0));
    check("rst_lo_q",      128'(bus.LO_Q_out),  128'(0));
    check_scan("rst", 3'd0, 4'h0);

    // Phase 0 pass-through and 2-cycle latency.
    send(16'h4000, 16'h1000, 14'h1000, 16'h4000, 16'h1000);
    @(negedge clk);
    check("lat_cycle1_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    check("lat_cycle2_valid", 128'(bus.out_valid), 128'(1));
    @(negedge clk);
    check("hold_valid", 128'(bus.out_valid), 128'(0));
    check("hold_rf",    128'(bus.RF_out), 128'({NTX{14'h1000}}));

    // Distinct lanes: RF lane k from DDS lane k, LO lane k from DDS lane 2k.
    @(posedge clk); #1;
    for (int k = 0; k < NTX; k++) begin
      bus.I_in[k*IB +: IB] = 16'h1000 + 16'(k * 16'h100);
      bus.Q_in[k*IB +: IB] = 16'h2000 + 16'(k * 16'h100);
      e.rf[k*NB +: NB]     = 14'h0400 + 14'(k * 14'h40);
    end
    for (int k = 0; k < NRX; k++) begin
      e.loi[k*IB +: IB] = 16'h1000 + 16'(2 * k * 16'h100);
      e.loq[k*IB +: IB] = 16'h2000 + 16'(2 * k * 16'h100);
    end
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Program CYCLOPS-like table and step through it.
    pulse(1'b0, 1'b0, 1'b1, 3'd0, 4'h0);
    pulse(1'b0, 1'b0, 1'b1, 3'd1, 4'h5);
    pulse(1'b0, 1'b0, 1'b1, 3'd2, 4'hA);
    pulse(1'b0, 1'b0, 1'b1, 3'd3, 4'hF);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("step1", 3'd1, 4'h5);
    send(16'h4000, 16'h1000, 14'h3C00, 16'hF000, 16'h4000);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("step2", 3'd2, 4'hA);
    send(16'h8000, 16'h1234, 14'h1FFF, 16'h7FFF, 16'hEDCC);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("step3", 3'd3, 4'hF);
    send(16'h4000, 16'h8000, 14'h2000, 16'h8000, 16'hC000);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("step4_wrap", 3'd0, 4'h0);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("step5", 3'd1, 4'h5);

    // Write and load of the same entry in one cycle: load sees old contents.
    pulse(1'b0, 1'b1, 1'b0, 3'd0, 4'h0);
    check_scan("restart", 3'd0, 4'h0);
    pulse(1'b1, 1'b0, 1'b1, 3'd1, 4'h3);
    check_scan("wr_same_cycle", 3'd1, 4'h5);
    pulse(1'b0, 1'b1, 1'b0, 3'd0, 4'h0);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("wr_next_visit", 3'd1, 4'h3);

    // Restart has priority over a simultaneous scan_done.
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("at2", 3'd2, 4'hA);
    pulse(1'b1, 1'b1, 1'b0, 3'd0, 4'h0);
    check_scan("restart_prio", 3'd0, 4'h0);

    // Shrinking the cycle below the pointer wraps on the next scan_done.
    repeat (3) pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("at3", 3'd3, 4'hF);
    bus.cycle_len = 4'd2;
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("shrink_wrap", 3'd0, 4'h0);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("len2_a", 3'd1, 4'h3);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("len2_b", 3'd0, 4'h0);

    // cycle_len = 0 behaves as 1.
    bus.cycle_len = 4'd0;
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("len0_a", 3'd0, 4'h0);
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("len0_b", 3'd0, 4'h0);

    // RX phase 270 only, then reset mid-stream.
    bus.cycle_len = 4'd4;
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("rx270", 3'd1, 4'h3);
    send(16'h4000, 16'h1000, 14'h1000, 16'h1000, 16'hC000);
    repeat (3) @(posedge clk);
    #1;
    bus.I_in     = {NTX{16'h1111}};
    bus.Q_in     = {NTX{16'h2222}};
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_rf",    128'(bus.RF_out),    128'(0));
    check("midrst_lo_i",  128'(bus.LO_I_out),  128'(0));
    check("midrst_lo_q",  128'(bus.LO_Q_out),  128'(0));
    check_scan("midrst", 3'd0, 4'h0);
    rst          = 1'b0;
    bus.I_in     = {NTX{16'h7FFF}};
    bus.Q_in     = {NTX{16'h8000}};
    bus.in_valid = 1'b1;
    e.rf  = {NTX{14'h1FFF}};
    e.loi = {NRX{16'h7FFF}};
    e.loq = {NRX{16'h8000}};
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("resume_cycle1_valid", 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    check("resume_cycle2_valid", 128'(bus.out_valid), 128'(1));

    // Table was cleared by reset.
    pulse(1'b1, 1'b0, 1'b0, 3'd0, 4'h0);
    check_scan("tbl_cleared", 3'd1, 4'h0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
